// File: rtl/gal_olmc_reg.sv
// Registered-mode GAL OLMC: $sop-encoded AND/OR array feeding one D register, pin and feedback.
// Define GAL_OLMC_AR_SP_EN for the 22V10-style cell with async-reset (ar) and sync-preset (sp) terms.
module gal_olmc_reg #(
    parameter int unsigned WIDTH  = 1,
    parameter int unsigned DEPTH  = 1,
    parameter              TABLE  = 2'b00,
    parameter int unsigned INVERT = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] A,
    input  logic             oe_n,
    input  logic             preload_en,
    input  logic             preload_d,
    output logic             Y,
    output logic             Y_oe,
    output logic             FB
`ifdef GAL_OLMC_AR_SP_EN
    ,
    input  logic             ar,
    input  logic             sp
`endif
);

    localparam int unsigned TW   = 2 * WIDTH * DEPTH;
    localparam int unsigned TW_S = (TW == 0) ? 2 : TW;
    localparam logic [TW_S-1:0] TBL = TW_S'(TABLE);
    localparam logic            INV = (INVERT != 0);

    if (DEPTH != 0 && $bits(TABLE) != TW) begin : g_bad_table
        $error("gal_olmc_reg: TABLE is %0d bits, expected 2*WIDTH*DEPTH = %0d", $bits(TABLE), TW);
    end

    logic sop;
    logic sp_w;
    logic q_q;
    logic q_d;

    // Literals are resolved at elaboration, so each term is a plain AND of wires/inversions/constants.
    if (DEPTH == 0) begin : g_const0
        assign sop = 1'b0;
    end else begin : g_array
        logic [DEPTH-1:0] term;
        for (genvar i = 0; i < DEPTH; i++) begin : g_term
            logic [WIDTH-1:0] lit;
            for (genvar j = 0; j < WIDTH; j++) begin : g_lit
                localparam logic [1:0] CODE = TBL[2*(i*WIDTH+j) +: 2];
                if (CODE == 2'b10) begin : g_pos
                    assign lit[j] = A[j];
                end else if (CODE == 2'b01) begin : g_neg
                    assign lit[j] = ~A[j];
                end else if (CODE == 2'b00) begin : g_dc
                    assign lit[j] = 1'b1;
                end else begin : g_kill
                    assign lit[j] = 1'b0;
                end
            end
            assign term[i] = &lit;
        end
        assign sop = |term;
    end

    always_comb begin
        q_d = sop;
        if (preload_en) begin
            q_d = preload_d;
        end else if (sp_w) begin
            q_d = 1'b1;
        end
    end

`ifdef GAL_OLMC_AR_SP_EN
    assign sp_w = sp;

    always_ff @(posedge clk or negedge rst_n or posedge ar) begin
        if (!rst_n || ar) begin
            q_q <= 1'b0;
        end else begin
            q_q <= q_d;
        end
    end
`else
    assign sp_w = 1'b0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_q <= 1'b0;
        end else begin
            q_q <= q_d;
        end
    end
`endif

    assign FB   = q_q;
    assign Y_oe = ~oe_n;
    assign Y    = oe_n ? 1'bz : (q_q ^ INV);

endmodule

// File: tb/tb_gal_olmc_reg.sv
// Directed scoreboard bench for gal_olmc_reg: three parameterisations share one stimulus stream.
// Define GAL_OLMC_AR_SP_EN to also exercise the ar/sp product terms.
module tb_gal_olmc_reg;

    typedef struct {
        string tag;
        logic  qa;
        logic  qd;
        logic  oe_n;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic [1:0] A = 2'b00;
    logic       oe_n = 1'b0;
    logic       preload_en = 1'b0;
    logic       preload_d = 1'b0;
    logic       ar = 1'b0;
    logic       sp = 1'b0;

    wire y_and, yoe_and, fb_and;
    wire y_inv, yoe_inv, fb_inv;
    wire y_d2, yoe_d2, fb_d2;

    int   checks = 0;
    int   failures = 0;
    exp_t sb[$];

    always #5 clk = ~clk;

    gal_olmc_reg #(.WIDTH(2), .DEPTH(1), .TABLE(4'b1010), .INVERT(0)) u_and (
        .clk(clk), .rst_n(rst_n), .A(A), .oe_n(oe_n),
        .preload_en(preload_en), .preload_d(preload_d),
        .Y(y_and), .Y_oe(yoe_and), .FB(fb_and)
`ifdef GAL_OLMC_AR_SP_EN
        , .ar(ar), .sp(sp)
`endif
    );

    gal_olmc_reg #(.WIDTH(2), .DEPTH(1), .TABLE(4'b1010), .INVERT(1)) u_inv (
        .clk(clk), .rst_n(rst_n), .A(A), .oe_n(oe_n),
        .preload_en(preload_en), .preload_d(preload_d),
        .Y(y_inv), .Y_oe(yoe_inv), .FB(fb_inv)
`ifdef GAL_OLMC_AR_SP_EN
        , .ar(ar), .sp(sp)
`endif
    );

    gal_olmc_reg #(.WIDTH(2), .DEPTH(2), .TABLE(8'b0001_0011), .INVERT(0)) u_d2 (
        .clk(clk), .rst_n(rst_n), .A(A), .oe_n(oe_n),
        .preload_en(preload_en), .preload_d(preload_d),
        .Y(y_d2), .Y_oe(yoe_d2), .FB(fb_d2)
`ifdef GAL_OLMC_AR_SP_EN
        , .ar(ar), .sp(sp)
`endif
    );

    task automatic chk(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic check_outputs(input exp_t e);
        chk({e.tag, ".fb_and"}, fb_and, e.qa);
        chk({e.tag, ".fb_inv"}, fb_inv, e.qa);
        chk({e.tag, ".fb_d2"}, fb_d2, e.qd);
        chk({e.tag, ".yoe_and"}, yoe_and, ~e.oe_n);
        chk({e.tag, ".yoe_d2"}, yoe_d2, ~e.oe_n);
        if (!e.oe_n) begin
            chk({e.tag, ".y_and"}, y_and, e.qa);
            chk({e.tag, ".y_inv"}, y_inv, ~e.qa);
            chk({e.tag, ".y_d2"}, y_d2, e.qd);
        end
    endtask

    // Model: reset/ar > preload > sp > sop; u_and/u_inv compute A0&A1, u_d2 computes ~A0.
    task automatic step(input string tag);
        exp_t e;
        logic na;
        logic nd;
        na = A[0] & A[1];
        nd = ~A[0];
        if (!rst_n || ar) begin
            na = 1'b0;
            nd = 1'b0;
        end else if (preload_en) begin
            na = preload_d;
            nd = preload_d;
        end else if (sp) begin
            na = 1'b1;
            nd = 1'b1;
        end
        e.tag  = tag;
        e.qa   = na;
        e.qd   = nd;
        e.oe_n = oe_n;
        sb.push_back(e);
        @(posedge clk);
        @(negedge clk);
        #1;
        check_outputs(sb.pop_front());
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Asynchronous reset before any clock edge.
        #1 rst_n = 1'b0;
        #1;
        chk("rst.fb_and", fb_and, 1'b0);
        chk("rst.fb_inv", fb_inv, 1'b0);
        chk("rst.fb_d2", fb_d2, 1'b0);
        chk("rst.y_and", y_and, 1'b0);
        chk("rst.y_inv", y_inv, 1'b1);
        chk("rst.yoe", yoe_inv, 1'b1);
        oe_n = 1'b1;
        #1;
        chk("rst_oe.yoe_and", yoe_and, 1'b0);
        chk("rst_oe.yoe_inv", yoe_inv, 1'b0);
        chk("rst_oe.fb_inv", fb_inv, 1'b0);
        oe_n = 1'b0;

        // Clock edge under reset with preload requested: reset must win.
        A = 2'b11; preload_en = 1'b1; preload_d = 1'b1;
        step("rst_vs_preload");
        rst_n = 1'b1; preload_en = 1'b0;

        A = 2'b11; step("and_11");
        A = 2'b01; step("and_01");
        A = 2'b00; step("a_00");
        A = 2'b10; step("a_10");

        // Preload overrides sop in both directions, then sop resumes.
        A = 2'b01; preload_en = 1'b1; preload_d = 1'b1; step("preload_1");
        preload_en = 1'b0; step("after_preload");
        A = 2'b11; preload_en = 1'b1; preload_d = 1'b0; step("preload_0_vs_and");
        A = 2'b10; step("preload_0_vs_d2");
        preload_en = 1'b0;

        // Mid-cycle reset pulse: outputs clear with no clock edge.
        A = 2'b11; step("pre_pulse");
        #1 rst_n = 1'b0;
        #1;
        chk("pulse.fb_and", fb_and, 1'b0);
        chk("pulse.fb_inv", fb_inv, 1'b0);
        chk("pulse.y_inv", y_inv, 1'b1);
        #1 rst_n = 1'b1;
        step("post_pulse");

        oe_n = 1'b1; A = 2'b00; step("oe_off");
        A = 2'b11; step("oe_off_fb");
        oe_n = 1'b0; step("oe_back");

        for (int k = 0; k < 12; k++) begin
            A          = 2'($urandom_range(0, 3));
            preload_en = ($urandom_range(0, 3) == 0);
            preload_d  = 1'($urandom_range(0, 1));
            oe_n       = ($urandom_range(0, 4) == 0);
            step($sformatf("rand%0d", k));
        end
        preload_en = 1'b0; oe_n = 1'b0;

`ifdef GAL_OLMC_AR_SP_EN
        A = 2'b01; sp = 1'b1; step("sp_set");
        sp = 1'b0;
        #1 ar = 1'b1;
        #1;
        chk("ar_async.fb_and", fb_and, 1'b0);
        chk("ar_async.fb_d2", fb_d2, 1'b0);
        preload_en = 1'b1; preload_d = 1'b1; step("ar_vs_preload");
        preload_en = 1'b0; sp = 1'b1; step("ar_vs_sp");
        ar = 1'b0; step("sp_after_ar");
        sp = 1'b0; A = 2'b11; step("sop_after_sp");
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
